convolution_nxn: RTL

Parametrised successor to the fixed 3x3 RGB565 convolution stage in the camera pipeline. Accepts one column of KSIZE vertically adjacent RGB565 pixels per valid cycle from the line buffer, holds a KSIZE x KSIZE sliding window, and applies a runtime-loadable signed kernel per channel with a power-of-two divide and output clamping. Sits between the line buffer and the display/threshold stages; hcount/vcount travel alongside the data with matched latency.

---
 rtl/convolution_nxn.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/convolution_nxn.sv
// convolution_nxn: KSIZE x KSIZE sliding-window convolution on RGB565 pixels.
// One column of KSIZE vertically adjacent pixels enters per valid cycle. Each
// channel is convolved with a runtime-loadable signed kernel, then shifted
// right (arithmetic) and clamped to the channel range. Pipeline stages:
// E0 window update, E1 registered products, E2 sum/shift/clamp to outputs.
// Optional build macro: CONV_ABS_EN -- take |result| before clamping
// (edge-magnitude mode); otherwise negative results clamp to 0.
module convolution_nxn #(
  parameter int KSIZE      = 3,
  parameter int COEF_WIDTH = 8,
  parameter int HWIDTH     = 11,
  parameter int VWIDTH     = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [KSIZE*16-1:0]   data_in,
  input  logic [HWIDTH-1:0]     hcount_in,
  input  logic [VWIDTH-1:0]     vcount_in,
  input  logic                  data_valid_in,
  input  logic                  coef_we_in,
  input  logic [4:0]            coef_addr_in,
  input  logic [COEF_WIDTH-1:0] coef_data_in,
  output logic [15:0]           line_out,
  output logic [HWIDTH-1:0]     hcount_out,
  output logic [VWIDTH-1:0]     vcount_out,
  output logic                  data_valid_out
);

  localparam int NTAP   = KSIZE * KSIZE;
  localparam int CENTRE = (KSIZE / 2) * KSIZE + (KSIZE / 2);
  localparam int PW     = COEF_WIDTH + 7;          // signed coef x 6-bit unsigned
  localparam int AW     = PW + $clog2(NTAP);       // sum of NTAP products

`ifdef CONV_ABS_EN
  localparam bit ABS_EN = 1'b1;
`else
  localparam bit ABS_EN = 1'b0;
`endif

  // Channel ch of an RGB565 pixel, zero-extended to 6 bits (0=R, 1=G, 2=B).
  function automatic logic [5:0] chan(input logic [15:0] p, input int ch);
    case (ch)
      0:       return {1'b0, p[15:11]};
      1:       return p[10:5];
      default: return {1'b0, p[4:0]};
    endcase
  endfunction

  // Signed coefficient times unsigned channel value.
  function automatic logic signed [PW-1:0] mul(input logic signed [COEF_WIDTH-1:0] c,
                                                input logic [5:0] px);
    logic signed [PW-1:0] pxs;
    pxs = signed'(PW'(px));
    return PW'(c) * pxs;
  endfunction

  // Saturate a signed value into [0, maxv].
  function automatic logic [5:0] clamp(input logic signed [AW-1:0] v, input logic [5:0] maxv);
    if (v[AW-1])                     return '0;
    if (v > signed'(AW'(maxv)))      return maxv;
    return v[5:0];
  endfunction

  logic signed [COEF_WIDTH-1:0] coef_q [NTAP];
  logic [3:0]                   shift_q;
  logic [15:0]                  win_q [KSIZE][KSIZE];   // [column][row]
  logic                         v0_q, v1_q, vout_q;
  logic [HWIDTH-1:0]            h0_q, h1_q, hout_q;
  logic [VWIDTH-1:0]            vc0_q, vc1_q, vcout_q;
  logic signed [PW-1:0]         prod_q [NTAP][3];
  logic [15:0]                  line_q, line_d;
  logic signed [AW-1:0]         acc_d [3];
  logic signed [AW-1:0]         res_d [3];
  logic [5:0]                   r_d, g_d, b_d;

  // Coefficient and shift bank, loaded by the write strobe; identity kernel at reset.
  // NOTE: this small register bank is reset explicitly, unlike a RAM, because the
  // identity kernel is the defined state after every reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NTAP; i++) coef_q[i] <= (i == CENTRE) ? COEF_WIDTH'(1) : '0;
      shift_q <= '0;
    end else if (coef_we_in) begin
      for (int i = 0; i < NTAP; i++)
        if (coef_addr_in == 5'(i)) coef_q[i] <= coef_data_in;
      if (coef_addr_in == 5'(NTAP)) shift_q <= coef_data_in[3:0];
    end
  end

  // E0: shift the window one column on valid input and capture its tags.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int c = 0; c < KSIZE; c++)
        for (int r = 0; r < KSIZE; r++) win_q[c][r] <= '0;
      v0_q  <= 1'b0;
      h0_q  <= '0;
      vc0_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, which is what makes the column shift correct.
      v0_q <= data_valid_in;
      if (data_valid_in) begin
        for (int c = 0; c < KSIZE - 1; c++)
          for (int r = 0; r < KSIZE; r++) win_q[c][r] <= win_q[c+1][r];
        for (int r = 0; r < KSIZE; r++) win_q[KSIZE-1][r] <= data_in[r*16 +: 16];
        h0_q  <= hcount_in;
        vc0_q <= vcount_in;
      end
    end
  end

  // E1: register every tap product per channel using the current coefficients.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int t = 0; t < NTAP; t++)
        for (int ch = 0; ch < 3; ch++) prod_q[t][ch] <= '0;
      v1_q  <= 1'b0;
      h1_q  <= '0;
      vc1_q <= '0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) begin
        for (int r = 0; r < KSIZE; r++)
          for (int c = 0; c < KSIZE; c++)
            for (int ch = 0; ch < 3; ch++)
              prod_q[r*KSIZE+c][ch] <= mul(coef_q[r*KSIZE+c], chan(win_q[c][r], ch));
        h1_q  <= h0_q;
        vc1_q <= vc0_q;
      end
    end
  end

  // Sum products, arithmetic shift, optional magnitude, then clamp per channel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred; accumulation uses blocking '='.
    for (int ch = 0; ch < 3; ch++) begin
      acc_d[ch] = '0;
      for (int t = 0; t < NTAP; t++) acc_d[ch] = acc_d[ch] + AW'(prod_q[t][ch]);
      res_d[ch] = acc_d[ch] >>> shift_q;
      if (ABS_EN && res_d[ch][AW-1]) res_d[ch] = -res_d[ch];
    end
    r_d    = clamp(res_d[0], 6'd31);
    g_d    = clamp(res_d[1], 6'd63);
    b_d    = clamp(res_d[2], 6'd31);
    line_d = {r_d[4:0], g_d, b_d[4:0]};
  end

  // E2: register the result and tags; outputs hold while no valid result arrives.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vout_q  <= 1'b0;
      line_q  <= '0;
      hout_q  <= '0;
      vcout_q <= '0;
    end else begin
      vout_q <= v1_q;
      if (v1_q) begin
        line_q  <= line_d;
        hout_q  <= h1_q;
        vcout_q <= vc1_q;
      end
    end
  end

  assign line_out       = line_q;
  assign hcount_out     = hout_q;
  assign vcount_out     = vcout_q;
  assign data_valid_out = vout_q;

endmodule
